// File: rtl/fs_pkg.sv
// fs_pkg: shared constants and helpers for the pipelined subtract-with-borrow unit.
package fs_pkg;

  localparam int FS_N_DEFAULT   = 4;
  localparam int FS_SEG_DEFAULT = 1;

  // Slice result as produced by one stage: borrow-out in the MSB, SEG result bits below.
  typedef logic [FS_SEG_DEFAULT:0] fs_slice_t;

  function automatic int fs_stages(input int n, input int seg);
    return n / seg;
  endfunction

endpackage

// File: rtl/fs_seg_stage.sv
// fs_seg_stage: one SEG-bit subtract-with-borrow slice with registered result,
// borrow and valid. Data registers load every cycle; only valid is cleared by flush.
module fs_seg_stage
  import fs_pkg::*;
#(
  parameter int SEG = FS_SEG_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_flush,
  input  logic           i_valid,
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_borrow,
  output logic           o_valid,
  output logic [SEG-1:0] o_diff,
  output logic           o_borrow
);

  logic           r_valid;
  logic [SEG-1:0] r_diff;
  logic           r_borrow;
  logic [SEG:0]   w_full;

  // Zero-extended difference: the extra MSB turns negative results into the borrow-out.
  assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{SEG{1'b0}}, i_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_valid  <= i_valid & ~i_flush;
      r_diff   <= w_full[SEG-1:0];
      r_borrow <= w_full[SEG];
    end
  end

  assign o_valid  = r_valid;
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;

endmodule

// File: rtl/fs_pipe_sub.sv
// fs_pipe_sub: pipelined N-bit a - b - bin, SEG bits resolved per stage, latency N/SEG + 1.
// Optional signed-overflow output ovf is built when FS_OVF_EN is defined.
module fs_pipe_sub
  import fs_pkg::*;
#(
  parameter int N   = FS_N_DEFAULT,
  parameter int SEG = FS_SEG_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  input  logic         flush,
  output logic         out_valid,
  output logic [N-1:0] d,
  output logic         bout
`ifdef FS_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int S = fs_stages(N, SEG);

  // Unconsumed operand bits after stage k (k = 0..S-1) sit packed back to back.
  function automatic int remOff(input int k);
    return k * N - (SEG * k * (k - 1)) / 2;
  endfunction

  // Earlier resolved slices carried alongside stage k (k = 2..S).
  function automatic int dsOff(input int k);
    return (SEG * (k - 2) * (k - 1)) / 2;
  endfunction

  localparam int REM_W = remOff(S);
  localparam int DS_W  = dsOff(S + 1);

  if (N < 1 || (N % SEG) != 0) begin : g_badCfg
    $fatal(1, "fs_pipe_sub: N must be >= 1 and a multiple of SEG");
  end

  logic             r_inValid;
  logic             r_inBin;
  logic [REM_W-1:0] r_aRem;
  logic [REM_W-1:0] r_bRem;
  wire  [REM_W-1:0] w_aRemNext;
  wire  [REM_W-1:0] w_bRemNext;
  wire  [S:0]       w_valid;
  wire  [S:0]       w_borrow;
  wire  [S*SEG-1:0] w_slice;

  assign w_aRemNext[N-1:0] = a;
  assign w_bRemNext[N-1:0] = b;
  assign w_valid[0]        = r_inValid;
  assign w_borrow[0]       = r_inBin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inValid <= 1'b0;
      r_inBin   <= 1'b0;
      r_aRem    <= '0;
      r_bRem    <= '0;
    end else begin
      r_inValid <= in_valid & ~flush;
      r_inBin   <= bin;
      r_aRem    <= w_aRemNext;
      r_bRem    <= w_bRemNext;
    end
  end

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int OFF = remOff(k - 1);

    fs_seg_stage #(.SEG(SEG)) u_seg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_flush  (flush),
      .i_valid  (w_valid[k-1]),
      .i_a      (r_aRem[OFF +: SEG]),
      .i_b      (r_bRem[OFF +: SEG]),
      .i_borrow (w_borrow[k-1]),
      .o_valid  (w_valid[k]),
      .o_diff   (w_slice[(k-1)*SEG +: SEG]),
      .o_borrow (w_borrow[k])
    );

    // Bits above the slice just consumed skew forward to the next stage.
    if (k < S) begin : g_skew
      assign w_aRemNext[remOff(k) +: N-k*SEG] = r_aRem[OFF+SEG +: N-k*SEG];
      assign w_bRemNext[remOff(k) +: N-k*SEG] = r_bRem[OFF+SEG +: N-k*SEG];
    end
  end

  if (S > 1) begin : g_deskew
    wire  [DS_W-1:0] w_dsNext;
    logic [DS_W-1:0] r_ds;

    for (genvar k = 2; k <= S; k++) begin : g_ds
      if (k == 2) begin : g_first
        assign w_dsNext[dsOff(2) +: SEG] = w_slice[0 +: SEG];
      end else begin : g_rest
        assign w_dsNext[dsOff(k) +: (k-1)*SEG] =
          {w_slice[(k-2)*SEG +: SEG], r_ds[dsOff(k-1) +: (k-2)*SEG]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ds <= '0;
      end else begin
        r_ds <= w_dsNext;
      end
    end

    assign d = {w_slice[(S-1)*SEG +: SEG], r_ds[dsOff(S) +: (S-1)*SEG]};
  end else begin : g_noDeskew
    assign d = w_slice;
  end

  assign out_valid = w_valid[S];
  assign bout      = w_borrow[S];

`ifdef FS_OVF_EN
  localparam int SGN_IDX = remOff(S - 1) + SEG - 1;

  logic r_aSgn;
  logic r_bSgn;

  // Operand sign bits ride into the final stage so ovf lines up with d and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSgn <= 1'b0;
      r_bSgn <= 1'b0;
    end else begin
      r_aSgn <= r_aRem[SGN_IDX];
      r_bSgn <= r_bRem[SGN_IDX];
    end
  end

  assign ovf = (r_aSgn ^ r_bSgn) & (d[N-1] ^ r_aSgn);
`endif

endmodule

// File: tb/tb_fs_pipe_sub.sv
// tb_fs_pipe_sub: scoreboard bench driving SEG=1, 2 and 4 instances of fs_pipe_sub (N=4) in parallel.
// ovf is checked only when FS_OVF_EN is defined.
`timescale 1ns/1ps
module tb_fs_pipe_sub;

  localparam int N    = 4;
  localparam int NDUT = 3;

  typedef struct {
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sbq [NDUT][$];
  int   lat [NDUT] = '{5, 3, 2};

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            inValid = 1'b0;
  logic            flush   = 1'b0;
  logic            bin     = 1'b0;
  logic [N-1:0]    a       = '0;
  logic [N-1:0]    b       = '0;
  logic [NDUT-1:0] outValid;
  logic [NDUT-1:0] bout;
  logic [NDUT-1:0] ovf;
  logic [N-1:0]    d [NDUT];

  int edgeCount = 0;
  int checks    = 0;
  int errors    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edgeCount++;

  fs_pipe_sub #(.N(N), .SEG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .a(a), .b(b), .bin(bin), .flush(flush),
    .out_valid(outValid[0]), .d(d[0]), .bout(bout[0])
`ifdef FS_OVF_EN
    , .ovf(ovf[0])
`endif
  );

  fs_pipe_sub #(.N(N), .SEG(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .a(a), .b(b), .bin(bin), .flush(flush),
    .out_valid(outValid[1]), .d(d[1]), .bout(bout[1])
`ifdef FS_OVF_EN
    , .ovf(ovf[1])
`endif
  );

  fs_pipe_sub #(.N(N), .SEG(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .a(a), .b(b), .bin(bin), .flush(flush),
    .out_valid(outValid[2]), .d(d[2]), .bout(bout[2])
`ifdef FS_OVF_EN
    , .ovf(ovf[2])
`endif
  );

`ifndef FS_OVF_EN
  assign ovf = '0;
`endif

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference result from integer arithmetic; ovf from the signed range of the true difference.
  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi, input int due);
    exp_t e;
    int   diff, sa, sb, sd;
    diff   = int'(av) - int'(bv) - int'(bi);
    e.d    = diff[N-1:0];
    e.bout = (diff < 0);
    sa     = av[N-1] ? int'(av) - (1 << N) : int'(av);
    sb     = bv[N-1] ? int'(bv) - (1 << N) : int'(bv);
    sd     = sa - sb - int'(bi);
    e.ovf  = (sd < -(1 << (N-1))) || (sd > (1 << (N-1)) - 1);
    e.due  = due;
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic bi, input logic fl);
    @(posedge clk);
    #1;
    inValid = v;
    a       = av;
    b       = bv;
    bin     = bi;
    flush   = fl;
    for (int i = 0; i < NDUT; i++) begin
      if (fl) begin
        while (sbq[i].size() > 0 && sbq[i][sbq[i].size()-1].due > edgeCount)
          void'(sbq[i].pop_back());
      end else if (v) begin
        sbq[i].push_back(model(av, bv, bi, edgeCount + lat[i]));
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("%s.dut%0d.out_valid", tag, i), 32'(outValid[i]), 32'd0);
      checkOutput($sformatf("%s.dut%0d.d", tag, i), 32'(d[i]), 32'd0);
      checkOutput($sformatf("%s.dut%0d.bout", tag, i), 32'(bout[i]), 32'd0);
`ifdef FS_OVF_EN
      checkOutput($sformatf("%s.dut%0d.ovf", tag, i), 32'(ovf[i]), 32'd0);
`endif
    end
  endtask

  // Output monitor: pops the scoreboard on out_valid and flags late, early or unexpected results.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        while (sbq[i].size() > 0 && sbq[i][0].due < edgeCount) begin
          checkOutput($sformatf("dut%0d.missing", i), 32'(edgeCount), 32'(sbq[i][0].due));
          void'(sbq[i].pop_front());
        end
        if (outValid[i]) begin
          if (sbq[i].size() == 0) begin
            checkOutput($sformatf("dut%0d.spurious", i), 32'(outValid[i]), 32'd0);
          end else begin
            e = sbq[i].pop_front();
            checkOutput($sformatf("dut%0d.latency", i), 32'(edgeCount), 32'(e.due));
            checkOutput($sformatf("dut%0d.d", i), 32'(d[i]), 32'(e.d));
            checkOutput($sformatf("dut%0d.bout", i), 32'(bout[i]), 32'(e.bout));
`ifdef FS_OVF_EN
            checkOutput($sformatf("dut%0d.ovf", i), 32'(ovf[i]), 32'(e.ovf));
`endif
          end
        end
      end
    end
  end

  initial begin
    #1;
    checkResetOutputs("por");
    #21;
    rst_n = 1'b1;

    // Directed single operations with idle gaps between them.
    applyStimulus(1'b1, 4'd9, 4'd3, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd3, 4'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd8, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd7, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 4'd2, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Back-to-back stream.
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] av, bv;
      av = N'(i);
      bv = N'(7 - i);
      applyStimulus(1'b1, av, bv, av[0], 1'b0);
    end
    repeat (6) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset with three operations in flight.
    applyStimulus(1'b1, 4'd12, 4'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd2, 4'd11, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    inValid = 1'b0;
    for (int i = 0; i < NDUT; i++) sbq[i].delete();
    #1;
    checkResetOutputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd10, 4'd4, 1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Flush with two in flight and a same-edge input, then a normal op.
    applyStimulus(1'b1, 4'd6, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd1, 4'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd14, 4'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'd11, 4'd13, 1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Random traffic with gaps and occasional flushes.
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, N'($urandom), N'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    repeat (8) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      checkOutput($sformatf("dut%0d.drain", i), 32'(sbq[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
